// File: rtl/cache_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : cache_arbiter_rr
//  Description : N-port cache-line arbiter between the L1 caches and a single
//                L2 / cacheline-adaptor port. One full line per transaction.
//                Round-robin or fixed-priority grant. The winning request is
//                latched and its response is routed only to the owning port.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_arbiter_rr #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int LINE_W    = 256,
    parameter int RR_MODE   = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_PORTS-1:0]           req_read,
    input  logic [NUM_PORTS-1:0]           req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]    req_addr,
    input  logic [NUM_PORTS*LINE_W-1:0]    req_wdata,
    output logic [LINE_W-1:0]              req_rdata,
    output logic [NUM_PORTS-1:0]           req_resp,
    output logic                           mem_read,
    output logic                           mem_write,
    output logic [ADDR_W-1:0]              mem_address,
    output logic [LINE_W-1:0]              mem_wdata,
    input  logic [LINE_W-1:0]              mem_rdata,
    input  logic                           mem_resp,
    output logic [$clog2(NUM_PORTS)-1:0]   grant_id,
    output logic                           busy
);

    localparam int c_ID_W = $clog2(NUM_PORTS);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_ID_W-1:0]   r_last;
    logic [c_ID_W-1:0]   r_grant;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [LINE_W-1:0]   r_wdata;

    logic [NUM_PORTS-1:0] w_pend;
    logic                 w_any;
    logic [c_ID_W-1:0]    w_win;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [LINE_W-1:0]    w_sel_wdata;
    logic                 w_sel_write;

    assign w_pend = req_read | req_write;
    assign w_any  = |w_pend;

    generate
        if (RR_MODE != 0) begin : g_rr
            logic              w_hi_found;
            logic [c_ID_W-1:0] w_hi_win;
            logic [c_ID_W-1:0] w_lo_win;

            // Round-robin: lowest pending index above the last grant, else wrap to lowest pending index.
            always_comb begin
                w_hi_found = 1'b0;
                w_hi_win   = '0;
                w_lo_win   = '0;
                for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                    if (w_pend[i]) begin
                        w_lo_win = c_ID_W'(i);
                        if (c_ID_W'(i) > r_last) begin
                            w_hi_found = 1'b1;
                            w_hi_win   = c_ID_W'(i);
                        end
                    end
                end
                w_win = w_hi_found ? w_hi_win : w_lo_win;
            end
        end else begin : g_fixed
            // Fixed priority: the lowest pending index always wins.
            always_comb begin
                w_win = '0;
                for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                    if (w_pend[i]) begin
                        w_win = c_ID_W'(i);
                    end
                end
            end
        end
    endgenerate

    // Select the winner's address, write line and operation for latching.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_win == c_ID_W'(i)) begin
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*LINE_W +: LINE_W];
                w_sel_write = req_write[i];
            end
        end
    end

    // Grant FSM: latch the winner in IDLE, hold the downstream request until mem_resp.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_last      <= c_ID_W'(NUM_PORTS - 1);
            r_grant     <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state     <= S_BUSY;
                        r_grant     <= w_win;
                        r_addr      <= w_sel_addr;
                        r_wdata     <= w_sel_wdata;
                        // Write wins when a caller illegally raises both.
                        r_mem_write <= w_sel_write;
                        r_mem_read  <= ~w_sel_write;
                    end
                end
                S_BUSY: begin
                    if (mem_resp) begin
                        r_state     <= S_IDLE;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_last      <= r_grant;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Completion pulse goes only to the owner; suppressed while reset abandons the transfer.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
            assign req_resp[gi] = reset_n && (r_state == S_BUSY) && mem_resp
                                  && (r_grant == c_ID_W'(gi));
        end
    endgenerate

    assign req_rdata   = mem_rdata;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_address = r_addr;
    assign mem_wdata   = r_wdata;
    assign grant_id    = r_grant;
    assign busy        = (r_state == S_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_arbiter_rr
//  Description : Self-checking bench for cache_arbiter_rr. A 2-port round-robin
//                instance is driven from a cycle table; 4-port round-robin and
//                fixed-priority instances are driven by short sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 2-port round-robin instance ----------------
    logic         rst_n2;
    logic [1:0]   rd2, wr2;
    logic [63:0]  addr2;
    logic [511:0] wdata2;
    logic [255:0] rdata2;
    logic [1:0]   rresp2;
    logic         mr2, mw2;
    logic [31:0]  maddr2;
    logic [255:0] mwdata2;
    logic [255:0] mrdata2;
    logic         mresp2;
    logic [0:0]   gid2;
    logic         busy2;

    cache_arbiter_rr #(.NUM_PORTS(2), .ADDR_W(32), .LINE_W(256), .RR_MODE(1)) dut2 (
        .clk(clk), .reset_n(rst_n2),
        .req_read(rd2), .req_write(wr2), .req_addr(addr2), .req_wdata(wdata2),
        .req_rdata(rdata2), .req_resp(rresp2),
        .mem_read(mr2), .mem_write(mw2), .mem_address(maddr2), .mem_wdata(mwdata2),
        .mem_rdata(mrdata2), .mem_resp(mresp2),
        .grant_id(gid2), .busy(busy2)
    );

    // ---------------- 4-port instances (RR and fixed) ----------------
    logic         rst_n4;
    logic [3:0]   rd4, wr4, rresp4;
    logic [127:0] addr4, wdata4;
    logic [31:0]  rdata4, maddr4, mwdata4, mrdata4;
    logic         mr4, mw4, mresp4, busy4;
    logic [1:0]   gid4;

    cache_arbiter_rr #(.NUM_PORTS(4), .ADDR_W(32), .LINE_W(32), .RR_MODE(1)) dut4 (
        .clk(clk), .reset_n(rst_n4),
        .req_read(rd4), .req_write(wr4), .req_addr(addr4), .req_wdata(wdata4),
        .req_rdata(rdata4), .req_resp(rresp4),
        .mem_read(mr4), .mem_write(mw4), .mem_address(maddr4), .mem_wdata(mwdata4),
        .mem_rdata(mrdata4), .mem_resp(mresp4),
        .grant_id(gid4), .busy(busy4)
    );

    logic [3:0]   rdf, wrf, rrespf;
    logic [31:0]  rdataf, maddrf, mwdataf;
    logic         mrf, mwf, mrespf, busyf;
    logic [1:0]   gidf;

    cache_arbiter_rr #(.NUM_PORTS(4), .ADDR_W(32), .LINE_W(32), .RR_MODE(0)) dutf (
        .clk(clk), .reset_n(rst_n4),
        .req_read(rdf), .req_write(wrf), .req_addr(addr4), .req_wdata(wdata4),
        .req_rdata(rdataf), .req_resp(rrespf),
        .mem_read(mrf), .mem_write(mwf), .mem_address(maddrf), .mem_wdata(mwdataf),
        .mem_rdata(mrdata4), .mem_resp(mrespf),
        .grant_id(gidf), .busy(busyf)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // One table row = one cycle of stimulus and the outputs expected before the next edge.
    typedef struct packed {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic        resp;
        logic        mr;
        logic        mw;
        logic        gid;
        logic [1:0]  rresp;
        logic        busy;
        logic [31:0] addr;
    } vec_t;

    localparam int NV = 23;
    vec_t vt [0:NV-1];

    localparam logic [255:0] AA   = {8{32'hAAAA_AAAA}};
    localparam logic [255:0] PAT  = {8{32'h1234_5678}};

    initial begin
        //            rd     wr     rsp   mr    mw    gid   rresp  busy  addr
        // Port 1 read at 0x40, response five cycles after mem_read rises.
        vt[0]  = '{2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0};
        vt[1]  = '{2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h40};
        vt[2]  = '{2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h40};
        vt[3]  = '{2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h40};
        vt[4]  = '{2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h40};
        vt[5]  = '{2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h40};
        vt[6]  = '{2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 32'h40};
        vt[7]  = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h40};
        // Stray mem_resp in IDLE: no completion pulse.
        vt[8]  = '{2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h40};
        // Both ports held: grants 0, 1, 0 with one idle cycle between.
        vt[9]  = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h40};
        vt[10] = '{2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'h1000};
        vt[11] = '{2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 32'h1000};
        vt[12] = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h1000};
        vt[13] = '{2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h40};
        vt[14] = '{2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 32'h40};
        vt[15] = '{2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h40};
        vt[16] = '{2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 32'h1000};
        vt[17] = '{2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 32'h1000};
        vt[18] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h1000};
        // Read and write both raised on port 0: write takes precedence.
        vt[19] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h1000};
        vt[20] = '{2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h1000};
        vt[21] = '{2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h1000};
        vt[22] = '{2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h1000};

        rst_n2 = 1'b0; rd2 = '0; wr2 = '0; mresp2 = 1'b0; mrdata2 = AA;
        addr2  = {32'h40, 32'h1000};
        wdata2 = {~PAT, PAT};
        rst_n4 = 1'b0; rd4 = '0; wr4 = '0; mresp4 = 1'b0; rdf = '0; wrf = '0; mrespf = 1'b0;
        mrdata4 = 32'h5555_5555;
        addr4  = {32'h103, 32'h102, 32'h101, 32'h100};
        wdata4 = {32'hD3, 32'hD2, 32'hD1, 32'hD0};

        repeat (2) @(negedge clk);
        #1;
        chk("rst2_busy", busy2, 0);
        chk("rst2_mem_read", mr2, 0);
        chk("rst2_grant_id", gid2, 0);
        chk("rst2_mem_address", maddr2, 0);
        chk("rst4_busy", busy4, 0);
        chk("rst4_grant_id", gid4, 0);
        @(negedge clk);
        rst_n2 = 1'b1;
        rst_n4 = 1'b1;

        // ---------------- table-driven 2-port run ----------------
        for (int v = 0; v < NV; v++) begin
            rd2 = vt[v].rd; wr2 = vt[v].wr; mresp2 = vt[v].resp;
            #1;
            chk($sformatf("v%0d_mem_read", v),    mr2,    vt[v].mr);
            chk($sformatf("v%0d_mem_write", v),   mw2,    vt[v].mw);
            chk($sformatf("v%0d_grant_id", v),    gid2,   vt[v].gid);
            chk($sformatf("v%0d_req_resp", v),    rresp2, vt[v].rresp);
            chk($sformatf("v%0d_busy", v),        busy2,  vt[v].busy);
            chk($sformatf("v%0d_mem_address", v), maddr2, vt[v].addr);
            chk($sformatf("v%0d_req_rdata", v),   rdata2, AA);
            @(negedge clk);
        end
        chk("wr_prec_wdata_latched", mwdata2, PAT);

        // ---------------- granted port changes addr/wdata mid-BUSY ----------------
        addr2 = {32'h40, 32'h100}; wdata2 = {~PAT, PAT}; wr2 = 2'b01; rd2 = 2'b00;
        #1 chk("chg_idle_busy", busy2, 0);
        @(negedge clk);
        addr2 = {32'h40, 32'h200}; wdata2 = {~PAT, ~PAT};
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("chg%0d_mem_address", c), maddr2, 32'h100);
            chk($sformatf("chg%0d_mem_wdata", c),   mwdata2, PAT);
            chk($sformatf("chg%0d_mem_write", c),   mw2, 1);
            @(negedge clk);
        end
        mresp2 = 1'b1;
        #1 chk("chg_req_resp", rresp2, 2'b01);
        @(negedge clk);
        mresp2 = 1'b0; wr2 = 2'b00;
        #1 chk("chg_done_mem_write", mw2, 0);
        chk("chg_done_busy", busy2, 0);

        // ---------------- reset during BUSY ----------------
        rd2 = 2'b10;
        @(negedge clk);
        #1 chk("rstb_grant_id", gid2, 1);
        chk("rstb_mem_read", mr2, 1);
        rst_n2 = 1'b0; rd2 = 2'b11;
        #1 chk("rstb_no_resp", rresp2, 2'b00);
        @(negedge clk);
        #1 chk("rstb_mem_read_drop", mr2, 0);
        chk("rstb_busy_drop", busy2, 0);
        chk("rstb_req_resp", rresp2, 2'b00);
        chk("rstb_grant_id0", gid2, 0);
        rst_n2 = 1'b1;
        @(negedge clk);
        #1 chk("rstb_first_grant", gid2, 0);
        chk("rstb_first_busy", busy2, 1);
        mresp2 = 1'b1;
        #1 chk("rstb_first_resp", rresp2, 2'b01);
        @(negedge clk);
        mresp2 = 1'b0; rd2 = 2'b00;

        // ---------------- fixed priority, ports 1 and 3 held ----------------
        rdf = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("fp%0d_idle", k), busyf, 0);
            @(negedge clk);
            #1 chk($sformatf("fp%0d_grant_id", k), gidf, 1);
            chk($sformatf("fp%0d_mem_address", k), maddrf, 32'h101);
            mrespf = 1'b1;
            #1 chk($sformatf("fp%0d_req_resp", k), rrespf, 4'b0010);
            @(negedge clk);
            mrespf = 1'b0;
        end
        rdf = 4'b0000;

        // ---------------- 4-port RR wrap-around from last=2 ----------------
        rd4 = 4'b0100;
        @(negedge clk);
        #1 chk("rr4_pre_grant", gid4, 2);
        mresp4 = 1'b1;
        @(negedge clk);
        mresp4 = 1'b0;
        rd4 = 4'b1111;
        #1 chk("rr4_idle_mem_read", mr4, 0);
        begin
            logic [1:0] exp_seq [0:3];
            logic [3:0] one;
            exp_seq[0] = 2'd3; exp_seq[1] = 2'd0; exp_seq[2] = 2'd1; exp_seq[3] = 2'd2;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                #1 chk($sformatf("rr4_%0d_grant_id", k), gid4, exp_seq[k]);
                chk($sformatf("rr4_%0d_mem_address", k), maddr4, 32'h100 + 32'(exp_seq[k]));
                chk($sformatf("rr4_%0d_mem_read", k), mr4, 1);
                mresp4 = 1'b1;
                one = 4'b0001 << exp_seq[k];
                #1 chk($sformatf("rr4_%0d_req_resp", k), rresp4, one);
                @(negedge clk);
                mresp4 = 1'b0;
                #1 chk($sformatf("rr4_%0d_gap", k), mr4, 0);
            end
        end
        rd4 = 4'b0000;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
